// File: rtl/mux4_pkg.sv
// Shared channel-index type and round-robin helper for the 4-to-1 stream mux.
package mux4_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic sel_t rr_next(input sel_t x);
        return x + sel_t'(1);
    endfunction

endpackage

// File: rtl/mux4to1_rr_arb4.sv
// Combinational round-robin arbiter: scans req_i starting at ptr_i and grants the first hit.
module rr_arb4
    import mux4_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  sel_t              ptr_i,
    input  logic              en_i,
    output logic [NUM_CH-1:0] gnt_o,
    output sel_t              sel_o,
    output logic              gnt_valid_o
);

    logic found_s;
    sel_t idx_s;

    // Priority scan from the pointer, wrapping modulo four.
    always_comb begin
        found_s = 1'b0;
        sel_o   = sel_t'(0);
        idx_s   = sel_t'(0);
        for (int k = 0; k < NUM_CH; k++) begin
            idx_s = ptr_i + sel_t'(k);
            if (!found_s && req_i[idx_s]) begin
                found_s = 1'b1;
                sel_o   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
        gnt_valid_o = en_i && found_s;
        if (gnt_valid_o) begin
            gnt_o = 4'b0001 << sel_o;
        end else begin
            gnt_o = 4'b0000;
        end
    end

endmodule

// File: rtl/mux4to1_rr.sv
// 4-to-1 valid/ready stream mux with round-robin arbitration and a registered output.
// Optional packet lock (IN_LAST/OUT_LAST) is enabled by defining MUX4TO1_PKT_LOCK_EN.
module mux4to1_rr
    import mux4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_CH-1:0]      IN_VALID,
    input  logic [NUM_CH*WIDTH-1:0] IN_DATA,
    output logic [NUM_CH-1:0]      IN_READY,
    output logic                   OUT_VALID,
    output logic [WIDTH-1:0]       OUT_DATA,
    output logic [SEL_W-1:0]       OUT_SEL,
    input  logic                   OUT_READY
`ifdef MUX4TO1_PKT_LOCK_EN
    ,
    input  logic [NUM_CH-1:0]      IN_LAST,
    output logic                   OUT_LAST
`endif
);

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    sel_t              out_sel_q, out_sel_d;
    sel_t              ptr_q, ptr_d;
    logic              load_s;
    logic              arb_en_s;
    logic [NUM_CH-1:0] req_s;
    logic [NUM_CH-1:0] gnt_s;
    sel_t              gnt_sel_s;
    logic              gnt_valid_s;
`ifdef MUX4TO1_PKT_LOCK_EN
    logic              lock_q, lock_d;
    sel_t              lock_ch_q, lock_ch_d;
    logic              out_last_q, out_last_d;
`endif

    // Load when the output register is empty or draining; never grant while in reset.
    always_comb begin
        load_s   = !out_valid_q || OUT_READY;
        arb_en_s = load_s && !RST;
`ifdef MUX4TO1_PKT_LOCK_EN
        if (lock_q) begin
            req_s = IN_VALID & (4'b0001 << lock_ch_q);
        end else begin
            req_s = IN_VALID;
        end
`else
        req_s = IN_VALID;
`endif
    end

    rr_arb4 u_arb (
        .req_i       (req_s),
        .ptr_i       (ptr_q),
        .en_i        (arb_en_s),
        .gnt_o       (gnt_s),
        .sel_o       (gnt_sel_s),
        .gnt_valid_o (gnt_valid_s)
    );

    assign IN_READY  = gnt_s;
    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_SEL   = out_sel_q;
`ifdef MUX4TO1_PKT_LOCK_EN
    assign OUT_LAST  = out_last_q;
`endif

    // Next-state for output register, pointer and packet lock.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
`ifdef MUX4TO1_PKT_LOCK_EN
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
        out_last_d  = out_last_q;
`endif
        if (gnt_valid_s) begin
            out_valid_d = 1'b1;
            out_data_d  = IN_DATA[gnt_sel_s*WIDTH +: WIDTH];
            out_sel_d   = gnt_sel_s;
`ifdef MUX4TO1_PKT_LOCK_EN
            // Pointer moves only when a packet finishes, so a locked burst is one turn.
            out_last_d = IN_LAST[gnt_sel_s];
            if (IN_LAST[gnt_sel_s]) begin
                lock_d = 1'b0;
                ptr_d  = rr_next(gnt_sel_s);
            end else begin
                lock_d    = 1'b1;
                lock_ch_d = gnt_sel_s;
            end
`else
            ptr_d = rr_next(gnt_sel_s);
`endif
        end else if (load_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= sel_t'(0);
            ptr_q       <= sel_t'(0);
`ifdef MUX4TO1_PKT_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= sel_t'(0);
            out_last_q  <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
`ifdef MUX4TO1_PKT_LOCK_EN
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
            out_last_q  <= out_last_d;
`endif
        end
    end

endmodule

// File: tb/tb_mux4to1_rr.sv
// Self-checking bench for mux4to1_rr: directed vector table, reset, random vs. reference model.
module tb_mux4to1_rr;

    localparam int WIDTH = 8;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [3:0]           IN_VALID;
    logic [4*WIDTH-1:0]   IN_DATA;
    logic [3:0]           IN_READY;
    logic                 OUT_VALID;
    logic [WIDTH-1:0]     OUT_DATA;
    logic [1:0]           OUT_SEL;
    logic                 OUT_READY;
`ifdef MUX4TO1_PKT_LOCK_EN
    logic [3:0]           IN_LAST;
    logic                 OUT_LAST;
`endif

    always #5 CLK = ~CLK;

    mux4to1_rr #(.WIDTH(WIDTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_DATA   (IN_DATA),
        .IN_READY  (IN_READY),
        .OUT_VALID (OUT_VALID),
        .OUT_DATA  (OUT_DATA),
        .OUT_SEL   (OUT_SEL),
        .OUT_READY (OUT_READY)
`ifdef MUX4TO1_PKT_LOCK_EN
        ,
        .IN_LAST   (IN_LAST),
        .OUT_LAST  (OUT_LAST)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic        rdy;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic [1:0]  exp_sel;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[20];

    // Reference model state
    int         m_ptr;
    logic       m_valid;
    logic [7:0] m_data;
    logic [1:0] m_sel;
    logic [3:0] pend;
    logic [7:0] pdata [4];

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic apply_inputs(input logic [3:0] v, input logic [31:0] d, input logic rdy);
        IN_VALID  = v;
        IN_DATA   = d;
        OUT_READY = rdy;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int n;
        int g;
        logic load;
        logic [3:0] exp_rdy;

        RST = 1'b1;
        IN_VALID = 4'b0000;
        IN_DATA = '0;
        OUT_READY = 1'b0;
`ifdef MUX4TO1_PKT_LOCK_EN
        IN_LAST = 4'b1111;
`endif
        repeat (2) @(posedge CLK);
        #1;
        IN_VALID = 4'b1111;
        #1;
        chk("reset_out_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("reset_out_data", {24'd0, OUT_DATA}, 32'd0);
        chk("reset_out_sel", {30'd0, OUT_SEL}, 32'd0);
        chk("reset_in_ready", {28'd0, IN_READY}, 32'd0);
        next_cycle();
        RST = 1'b0;

        // Directed table: round robin, single channel, wrap, drain, stall
        n = 0;
        for (int i = 0; i < 8; i++) begin
            vecs[n] = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001 << (i % 4), 1'b1,
                        2'(i % 4), 8'hA0 + 8'(i % 4)};
            n++;
        end
        vecs[n] = '{4'b0100, 32'h005C0000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h5C}; n++;
        vecs[n] = '{4'b1000, 32'hD3000000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3}; n++;
        vecs[n] = '{4'b1001, 32'hD30000D0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hD0}; n++;
        vecs[n] = '{4'b1001, 32'hD30000D0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3}; n++;
        vecs[n] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'hD3}; n++;
        vecs[n] = '{4'b0010, 32'h00001100, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11}; n++;
        for (int i = 0; i < 3; i++) begin
            vecs[n] = '{4'b1111, 32'hC3C2C1C0, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h11};
            n++;
        end
        vecs[n] = '{4'b1111, 32'hC3C2C1C0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hC2}; n++;

        for (int i = 0; i < n; i++) begin
            apply_inputs(vecs[i].v, vecs[i].d, vecs[i].rdy);
            chk($sformatf("vec%0d_in_ready", i), {28'd0, IN_READY}, {28'd0, vecs[i].exp_ready});
            next_cycle();
            chk($sformatf("vec%0d_out_valid", i), {31'd0, OUT_VALID}, {31'd0, vecs[i].exp_ov});
            chk($sformatf("vec%0d_out_sel", i), {30'd0, OUT_SEL}, {30'd0, vecs[i].exp_sel});
            chk($sformatf("vec%0d_out_data", i), {24'd0, OUT_DATA}, {24'd0, vecs[i].exp_data});
        end

        // Asynchronous reset while a beat is held, away from any clock edge
        OUT_READY = 1'b0;
        #1;
        RST = 1'b1;
        #1;
        chk("async_rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("async_rst_out_sel", {30'd0, OUT_SEL}, 32'd0);
        chk("async_rst_out_data", {24'd0, OUT_DATA}, 32'd0);
        chk("async_rst_in_ready", {28'd0, IN_READY}, 32'd0);
        next_cycle();
        RST = 1'b0;

        // After reset, arbitration must restart at channel 0
        apply_inputs(4'b1111, 32'hB3B2B1B0, 1'b1);
        chk("post_rst_grant", {28'd0, IN_READY}, 32'h1);
        next_cycle();
        chk("post_rst_sel", {30'd0, OUT_SEL}, 32'd0);
        chk("post_rst_data", {24'd0, OUT_DATA}, 32'hB0);

        // Random traffic against the reference model
        IN_VALID = 4'b0000;
        RST = 1'b1;
        #1;
        next_cycle();
        RST = 1'b0;
        m_ptr = 0; m_valid = 1'b0; m_data = 8'h00; m_sel = 2'd0;
        pend = 4'b0000;
        for (int c = 0; c < 4; c++) pdata[c] = 8'h00;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int c = 0; c < 4; c++) begin
                if (!pend[c] && ($urandom % 3 != 0)) begin
                    pend[c] = 1'b1;
                    pdata[c] = 8'($urandom);
                end
            end
            apply_inputs(pend, {pdata[3], pdata[2], pdata[1], pdata[0]}, ($urandom % 4) != 0);
            load = !m_valid || OUT_READY;
            g = load ? pick(pend, m_ptr) : -1;
            exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            chk("rand_in_ready", {28'd0, IN_READY}, {28'd0, exp_rdy});
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data = pdata[g];
                m_sel = 2'(g);
                m_ptr = (g + 1) % 4;
                pend[g] = 1'b0;
            end else if (load) begin
                m_valid = 1'b0;
            end
            next_cycle();
            chk("rand_out_valid", {31'd0, OUT_VALID}, {31'd0, m_valid});
            chk("rand_out_sel", {30'd0, OUT_SEL}, {30'd0, m_sel});
            chk("rand_out_data", {24'd0, OUT_DATA}, {24'd0, m_data});
        end

`ifdef MUX4TO1_PKT_LOCK_EN
        // Packet lock: move the pointer to ch1, then ch1 sends a 3-beat packet against ch0/ch2
        RST = 1'b1;
        #1;
        next_cycle();
        RST = 1'b0;
        IN_LAST = 4'b1111;
        apply_inputs(4'b0001, 32'h000000E0, 1'b1);
        next_cycle();
        for (int b = 0; b < 3; b++) begin
            IN_LAST = (b == 2) ? 4'b1111 : 4'b1101;
            apply_inputs(4'b0111, {8'h00, 8'hE2, 8'h10 + 8'(b), 8'hE0}, 1'b1);
            chk($sformatf("lock_b%0d_grant", b), {28'd0, IN_READY}, 32'h2);
            next_cycle();
            chk($sformatf("lock_b%0d_sel", b), {30'd0, OUT_SEL}, 32'd1);
            chk($sformatf("lock_b%0d_data", b), {24'd0, OUT_DATA}, 32'h10 + b);
            chk($sformatf("lock_b%0d_last", b), {31'd0, OUT_LAST}, (b == 2) ? 32'd1 : 32'd0);
        end
        IN_LAST = 4'b1111;
        apply_inputs(4'b0101, 32'h00E200E0, 1'b1);
        next_cycle();
        chk("lock_release_sel", {30'd0, OUT_SEL}, 32'd2);
        chk("lock_release_data", {24'd0, OUT_DATA}, 32'hE2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
